// File: rtl/valid_bit_array.sv
// 64-entry line-valid bit array with single-cycle lookup, write-first bypass
// and a four-cycle grouped flush sequencer.
module valid_bit_array #(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [5:0]  wr_idx,
    input  logic        wr_val,
    input  logic        rd_en,
    input  logic [5:0]  rd_idx,
    output logic        rd_vld,
    output logic        rd_data,
    input  logic        flush_req,
    output logic        busy,
    output logic        flush_done,
    output logic [15:0] grp0,
    output logic [15:0] grp1,
    output logic [15:0] grp2,
    output logic [15:0] grp3
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         grp_cnt;
    logic [ENTRIES-1:0] vbits;
    logic               idle;
    logic               lookup;

    assign idle = (state == IDLE);

    // Same-index write in the lookup cycle wins over the stored bit.
    always_comb begin
        lookup = vbits[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            lookup = wr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grp_cnt    <= '0;
            vbits      <= '0;
            rd_vld     <= 1'b0;
            rd_data    <= 1'b0;
            busy       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            rd_vld  <= rd_en;
            rd_data <= rd_en && idle && lookup;

            case (state)
                IDLE: begin
                    flush_done <= 1'b0;
                    if (wr_en) begin
                        vbits[wr_idx] <= wr_val;
                    end
                    if (flush_req) begin
                        state   <= CLR;
                        grp_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLR: begin
                    vbits[{grp_cnt, 4'b0000} +: 16] <= '0;
                    grp_cnt <= grp_cnt + 2'd1;
                    if (grp_cnt == 2'd3) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    flush_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

    assign grp0 = vbits[15:0];
    assign grp1 = vbits[31:16];
    assign grp2 = vbits[47:32];
    assign grp3 = vbits[63:48];

endmodule

// File: tb/tb_valid_bit_array.sv
// Directed bench for valid_bit_array: reference model of the array and flush
// phase, read results scoreboarded through a queue.
module tb_valid_bit_array;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_idx;
    logic        wr_val;
    logic        rd_en;
    logic [5:0]  rd_idx;
    logic        rd_vld;
    logic        rd_data;
    logic        flush_req;
    logic        busy;
    logic        flush_done;
    logic [15:0] grp0, grp1, grp2, grp3;

    valid_bit_array #(.ENTRIES(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_val     (wr_val),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .flush_req  (flush_req),
        .busy       (busy),
        .flush_done (flush_done),
        .grp0       (grp0),
        .grp1       (grp1),
        .grp2       (grp2),
        .grp3       (grp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [63:0] model;
    int          phase;      // 0 idle, 1..4 clearing group phase-1, 5 done
    logic        sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic we, input logic [5:0] wi, input logic wv,
                         input logic re, input logic [5:0] ri, input logic fr);
        logic exp_vld;
        logic exp_rd;
        wr_en = we; wr_idx = wi; wr_val = wv;
        rd_en = re; rd_idx = ri; flush_req = fr;
        exp_vld = re;
        if (re) begin
            if (phase != 0)                 exp_rd = 1'b0;
            else if (we && (wi == ri))      exp_rd = wv;
            else                            exp_rd = model[ri];
            sb_q.push_back(exp_rd);
        end
        if (phase == 0) begin
            if (we) model[wi] = wv;
            if (fr) phase = 1;
        end else if (phase <= 4) begin
            model[(phase-1)*16 +: 16] = 16'h0000;
            phase = phase + 1;
        end else begin
            phase = 0;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush_req = 1'b0;
        chk("rd_vld", {63'd0, rd_vld}, {63'd0, exp_vld});
        if (rd_vld) begin
            if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
            else                  chk("rd_data", {63'd0, rd_data}, {63'd0, sb_q.pop_front()});
        end else begin
            chk("rd_data_idle", {63'd0, rd_data}, 64'd0);
        end
        chk("busy", {63'd0, busy}, {63'd0, (phase >= 1 && phase <= 4)});
        chk("flush_done", {63'd0, flush_done}, {63'd0, (phase == 5)});
        chk("grp", {grp3, grp2, grp1, grp0}, model);
        if (flush_done) done_cnt++;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        model = '0; phase = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_val = 1'b0;
        rd_en = 1'b0; rd_idx = '0; flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grp", {grp3, grp2, grp1, grp0}, 64'd0);
        chk("reset_out", {60'd0, rd_vld, rd_data, busy, flush_done}, 64'd0);
        rst_n = 1'b1;

        // Write 37 then look it up.
        cycle(1'b1, 6'd37, 1'b1, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 6'd37, 1'b0);
        chk("grp2_37", {48'd0, grp2}, 64'h0020);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 6'd36, 1'b0);

        // Same-cycle write/read bypass, then clearing write bypass.
        cycle(1'b1, 6'd5, 1'b1, 1'b1, 6'd5, 1'b0);
        cycle(1'b1, 6'd37, 1'b0, 1'b1, 6'd37, 1'b0);
        cycle(1'b1, 6'd0, 1'b1, 1'b1, 6'd63, 1'b0);
        cycle(1'b1, 6'd63, 1'b1, 1'b1, 6'd0, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 6'd63, 1'b0);

        // Fill all bits with interleaved lookups of the previous index.
        for (int i = 0; i < 64; i++)
            cycle(1'b1, 6'(i), 1'b1, (i % 3) == 0, 6'(i + 63), 1'b0);
        chk("all_set", {grp3, grp2, grp1, grp0}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Flush with write 60 during CLR, reads in CLR/DONE, second request ignored.
        done_cnt = 0;
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1);
        cycle(1'b1, 6'd60, 1'b1, 1'b1, 6'd60, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 6'd50, 1'b0);
        cycle(1'b1, 6'd60, 1'b1, 1'b0, 6'd0, 1'b0);
        cycle(1'b1, 6'd61, 1'b1, 1'b1, 6'd61, 1'b0);
        repeat (6) idle_cycle();
        chk("one_done", 64'(done_cnt), 64'd1);
        chk("flushed", {grp3, grp2, grp1, grp0}, 64'd0);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 6'd60, 1'b0);

        // Flush accepted together with a write and a read in IDLE.
        cycle(1'b1, 6'd10, 1'b1, 1'b0, 6'd0, 1'b0);
        cycle(1'b1, 6'd20, 1'b1, 1'b1, 6'd10, 1'b1);
        repeat (6) idle_cycle();
        chk("flush_wr_cleared", {grp3, grp2, grp1, grp0}, 64'd0);

        // Reset asserted between edges during CLR.
        cycle(1'b1, 6'd3, 1'b1, 1'b0, 6'd0, 1'b0);
        done_cnt = 0;
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_grp", {grp3, grp2, grp1, grp0}, 64'd0);
        chk("rst_mid_out", {60'd0, rd_vld, rd_data, busy, flush_done}, 64'd0);
        model = '0; phase = 0; sb_q.delete();
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 6'd63, 1'b1, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 6'd63, 1'b0);
        repeat (5) idle_cycle();
        chk("no_done_after_rst", 64'(done_cnt), 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
